// File: rtl/line_fit.sv
// Least-squares line fitter: accumulates object pixel moments per frame, then fits
// y = m*x + b and the centre of mass using one shared sequential signed divider.
module line_fit #(
    parameter int DIV_W = 64,
    parameter int FRAC  = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_valid_in,
    input  logic        tabulate_in,
    output logic [24:0] m_out,
    output logic [24:0] b_out,
    output logic [10:0] x_com_out,
    output logic [9:0]  y_com_out,
    output logic        vertical_out,
    output logic        empty_out,
    output logic        busy_out,
    output logic        valid_out
);
    localparam int CNT_W = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W);
    localparam logic signed [DIV_W-1:0] SAT_POS = DIV_W'(25'h0FFFFFF);

    typedef enum logic [3:0] {
        ACCUM, SNAP, MUL, DIV_M, MUL_B, DIV_B, DIV_X, DIV_Y, OUT
    } state_t;

    state_t state_reg, state_next;

    logic [19:0] acc_n_reg,   fit_n_reg;
    logic [30:0] acc_sx_reg,  fit_sx_reg;
    logic [29:0] acc_sy_reg,  fit_sy_reg;
    logic [41:0] acc_sxx_reg, fit_sxx_reg;
    logic [40:0] acc_sxy_reg, fit_sxy_reg;

    logic [DIV_W-1:0] num_reg, den_reg, bnum_reg;
    logic [24:0]      m_fit_reg, b_fit_reg;
    logic [10:0]      x_fit_reg;

    logic [DIV_W-1:0] dvd_reg, dvs_reg, rem_reg;
    logic             neg_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             snap, in_div, div_done, rem_ge;
    logic [21:0]      px_xx;
    logic [20:0]      px_xy;
    logic [DIV_W-1:0] ld_a, ld_b, quo_s, m_ext;
    logic [DIV_W:0]   rem_shift, rem_sub;
    logic [24:0]      q_sat;

    function automatic logic [24:0] sat25(input logic [DIV_W-1:0] v);
        if ($signed(v) > SAT_POS)
            return 25'h0FFFFFF;
        else if ($signed(v) < -SAT_POS)
            return 25'h1000001;
        else
            return v[24:0];
    endfunction

    assign snap     = (state_reg == SNAP);
    assign in_div   = (state_reg == DIV_M) || (state_reg == DIV_B) ||
                      (state_reg == DIV_X) || (state_reg == DIV_Y);
    assign div_done = in_div && (cnt_reg == CNT_LAST);
    assign busy_out = (state_reg != ACCUM);

    assign px_xx = 22'(hcount_in) * 22'(hcount_in);
    assign px_xy = 21'(hcount_in) * 21'(vcount_in);

    // Restoring step: the dividend register shifts out its top bit and the quotient shifts in.
    assign rem_shift = {rem_reg, dvd_reg[DIV_W-1]};
    assign rem_sub   = rem_shift - {1'b0, dvs_reg};
    assign rem_ge    = ~rem_sub[DIV_W];
    assign quo_s     = neg_reg ? -dvd_reg : dvd_reg;
    assign q_sat     = sat25(quo_s);
    assign m_ext     = {{(DIV_W-25){q_sat[24]}}, q_sat};

    always_comb begin
        ld_a = '0;
        ld_b = '0;
        case (state_reg)
            DIV_M: begin
                ld_a = num_reg << FRAC;
                ld_b = den_reg;
            end
            DIV_B: begin
                ld_a = bnum_reg;
                ld_b = DIV_W'(fit_n_reg);
            end
            DIV_X: begin
                ld_a = DIV_W'(fit_sx_reg);
                ld_b = DIV_W'(fit_n_reg);
            end
            DIV_Y: begin
                ld_a = DIV_W'(fit_sy_reg);
                ld_b = DIV_W'(fit_n_reg);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM: if (tabulate_in) state_next = SNAP;
            SNAP:  state_next = MUL;
            MUL:   state_next = DIV_M;
            DIV_M: if (div_done) state_next = MUL_B;
            MUL_B: state_next = DIV_B;
            DIV_B: if (div_done) state_next = DIV_X;
            DIV_X: if (div_done) state_next = DIV_Y;
            DIV_Y: if (div_done) state_next = OUT;
            OUT:   state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_reg <= ACCUM;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_n_reg    <= '0;
            acc_sx_reg   <= '0;
            acc_sy_reg   <= '0;
            acc_sxx_reg  <= '0;
            acc_sxy_reg  <= '0;
            fit_n_reg    <= '0;
            fit_sx_reg   <= '0;
            fit_sy_reg   <= '0;
            fit_sxx_reg  <= '0;
            fit_sxy_reg  <= '0;
            num_reg      <= '0;
            den_reg      <= '0;
            bnum_reg     <= '0;
            m_fit_reg    <= '0;
            b_fit_reg    <= '0;
            x_fit_reg    <= '0;
            dvd_reg      <= '0;
            dvs_reg      <= '0;
            rem_reg      <= '0;
            neg_reg      <= 1'b0;
            cnt_reg      <= '0;
            m_out        <= '0;
            b_out        <= '0;
            x_com_out    <= '0;
            y_com_out    <= '0;
            vertical_out <= 1'b0;
            empty_out    <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            // SNAP restarts the sums so pixels arriving while busy open the next frame.
            acc_n_reg   <= (snap ? '0 : acc_n_reg)   + (pixel_valid_in ? 20'd1 : 20'd0);
            acc_sx_reg  <= (snap ? '0 : acc_sx_reg)  + (pixel_valid_in ? 31'(hcount_in) : 31'd0);
            acc_sy_reg  <= (snap ? '0 : acc_sy_reg)  + (pixel_valid_in ? 30'(vcount_in) : 30'd0);
            acc_sxx_reg <= (snap ? '0 : acc_sxx_reg) + (pixel_valid_in ? 42'(px_xx) : 42'd0);
            acc_sxy_reg <= (snap ? '0 : acc_sxy_reg) + (pixel_valid_in ? 41'(px_xy) : 41'd0);

            case (state_reg)
                SNAP: begin
                    fit_n_reg   <= acc_n_reg;
                    fit_sx_reg  <= acc_sx_reg;
                    fit_sy_reg  <= acc_sy_reg;
                    fit_sxx_reg <= acc_sxx_reg;
                    fit_sxy_reg <= acc_sxy_reg;
                end
                MUL: begin
                    num_reg <= DIV_W'(fit_n_reg) * DIV_W'(fit_sxy_reg)
                             - DIV_W'(fit_sx_reg) * DIV_W'(fit_sy_reg);
                    den_reg <= DIV_W'(fit_n_reg) * DIV_W'(fit_sxx_reg)
                             - DIV_W'(fit_sx_reg) * DIV_W'(fit_sx_reg);
                end
                MUL_B: begin
                    m_fit_reg <= q_sat;
                    bnum_reg  <= (DIV_W'(fit_sy_reg) << FRAC) - m_ext * DIV_W'(fit_sx_reg);
                end
                default: ;
            endcase

            if (in_div) begin
                if (cnt_reg == '0) begin
                    dvd_reg <= ld_a[DIV_W-1] ? -ld_a : ld_a;
                    dvs_reg <= ld_b[DIV_W-1] ? -ld_b : ld_b;
                    neg_reg <= ld_a[DIV_W-1] ^ ld_b[DIV_W-1];
                    rem_reg <= '0;
                    // The load cycle is the last chance to read the previous quotient.
                    if (state_reg == DIV_X) b_fit_reg <= q_sat;
                    if (state_reg == DIV_Y) x_fit_reg <= quo_s[10:0];
                end else begin
                    rem_reg <= rem_ge ? rem_sub[DIV_W-1:0] : rem_shift[DIV_W-1:0];
                    dvd_reg <= {dvd_reg[DIV_W-2:0], rem_ge};
                end
                cnt_reg <= div_done ? '0 : cnt_reg + CNT_W'(1);
            end

            valid_out <= (state_reg == OUT);
            if (state_reg == OUT) begin
                if (fit_n_reg == '0) begin
                    m_out        <= '0;
                    b_out        <= '0;
                    x_com_out    <= '0;
                    y_com_out    <= '0;
                    vertical_out <= 1'b0;
                    empty_out    <= 1'b1;
                end else if (den_reg == '0) begin
                    m_out        <= 25'h0FFFFFF;
                    b_out        <= {6'd0, x_fit_reg, 8'd0};
                    x_com_out    <= x_fit_reg;
                    y_com_out    <= quo_s[9:0];
                    vertical_out <= 1'b1;
                    empty_out    <= 1'b0;
                end else begin
                    m_out        <= m_fit_reg;
                    b_out        <= b_fit_reg;
                    x_com_out    <= x_fit_reg;
                    y_com_out    <= quo_s[9:0];
                    vertical_out <= 1'b0;
                    empty_out    <= 1'b0;
                end
            end
        end
    end
endmodule
